// File: rtl/fp_acc_arbiter_pkg.sv
// Shared types for the FP32 accumulator arbiter:
// opcode enum, FP32 word type and constants.
package fp_arb_pkg;

    typedef logic [31:0] fp32_t;

    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_ACC_LD  = 2'b01,
        OP_ACC_ADD = 2'b10
    } fp_op_t;

    localparam fp32_t FP_ZERO = 32'h0000_0000;
    localparam fp32_t FP_QNAN = 32'h7FC0_0000;

    // Code 2'b11 is folded into a plain ADD.
    function automatic fp_op_t decode_op(input logic [1:0] code);
        case (code)
            2'b01:   decode_op = OP_ACC_LD;
            2'b10:   decode_op = OP_ACC_ADD;
            default: decode_op = OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/fp_acc_arbiter_if.sv
// Request/result bundle between the requesters and
// fp_acc_arbiter; master = requester side, slave = arbiter.
interface fp_acc_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0][1:0]  op;
    logic [NREQ-1:0][31:0] a;
    logic [NREQ-1:0][31:0] b;
    logic [NREQ-1:0]       gnt;
    logic                  res_vld;
    logic [IDW-1:0]        res_id;
    logic [31:0]           res;
    logic [NREQ-1:0][31:0] acc;

    modport master (
        output req, op, a, b,
        input  gnt, res_vld, res_id, res, acc
    );

    modport slave (
        input  req, op, a, b,
        output gnt, res_vld, res_id, res, acc
    );
endinterface

// File: rtl/fp_acc_arbiter_fp_adder.sv
// Combinational FP32 adder, round-to-nearest-even;
// subnormal inputs and results flush to signed zero.
module FP_adder import fp_arb_pkg::*; (
    input  fp32_t a,
    input  fp32_t b,
    output fp32_t sum
);
    logic [7:0]  ea, eb;
    logic        nan_a, nan_b;
    logic        sx, inc, found;
    int          ex, ey, d, e, lz;
    logic [26:0] mx, my, sh;
    logic [27:0] s;
    logic [24:0] rm;

    assign ea    = a[30:23];
    assign eb    = b[30:23];
    assign nan_a = (ea == 8'hFF) && (a[22:0] != '0);
    assign nan_b = (eb == 8'hFF) && (b[22:0] != '0);

    always_comb begin
        sum   = FP_ZERO;
        sx    = 1'b0;
        inc   = 1'b0;
        found = 1'b0;
        ex    = 0;
        ey    = 0;
        d     = 0;
        e     = 0;
        lz    = 0;
        mx    = '0;
        my    = '0;
        sh    = '0;
        s     = '0;
        rm    = '0;
        if (nan_a || nan_b)
            sum = FP_QNAN;
        else if (ea == 8'hFF && eb == 8'hFF)
            sum = (a[31] == b[31]) ? a : FP_QNAN;
        else if (ea == 8'hFF)
            sum = a;
        else if (eb == 8'hFF)
            sum = b;
        else if (ea == 8'h00 && eb == 8'h00)
            sum = {a[31] & b[31], 31'd0};
        else if (ea == 8'h00)
            sum = b;
        else if (eb == 8'h00)
            sum = a;
        else begin
            if (a[30:0] >= b[30:0]) begin
                sx = a[31];
                ex = int'(ea);
                ey = int'(eb);
                mx = {1'b1, a[22:0], 3'b000};
                my = {1'b1, b[22:0], 3'b000};
            end else begin
                sx = b[31];
                ex = int'(eb);
                ey = int'(ea);
                mx = {1'b1, b[22:0], 3'b000};
                my = {1'b1, a[22:0], 3'b000};
            end
            d = ex - ey;
            // Bits shifted out collapse into the sticky LSB.
            if (d > 26)
                sh = 27'd1;
            else begin
                sh    = my >> d;
                sh[0] = sh[0] | (|(my & ((27'd1 << d) - 27'd1)));
            end
            e = ex;
            if (a[31] == b[31]) begin
                s = {1'b0, mx} + {1'b0, sh};
                if (s[27]) begin
                    s = {1'b0, s[27:2], s[1] | s[0]};
                    e = e + 1;
                end
            end else begin
                s = {1'b0, mx} - {1'b0, sh};
                for (int k = 26; k >= 0; k--) begin
                    if (!found && s[k]) begin
                        found = 1'b1;
                        lz    = 26 - k;
                    end
                end
                s = s << lz;
                e = e - lz;
            end
            inc = s[2] & (s[1] | s[0] | s[3]);
            rm  = {1'b0, s[26:3]} + {24'd0, inc};
            if (rm[24]) begin
                rm = rm >> 1;
                e  = e + 1;
            end
            if (a[31] != b[31] && !found)
                sum = FP_ZERO;
            else if (e >= 255)
                sum = {sx, 8'hFF, 23'd0};
            else if (e <= 0)
                sum = {sx, 31'd0};
            else
                sum = {sx, 8'(e), 23'(rm)};
        end
    end

endmodule

// File: rtl/fp_acc_arbiter_rr_arbiter.sv
// One-hot round-robin arbiter; mask bits block requesters,
// pointer advances past each granted index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);
    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] elig;
    logic            hit;
    int              idx;

    always_comb begin
        elig    = req & ~mask;
        gnt     = '0;
        gnt_idx = '0;
        hit     = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!hit && elig[idx]) begin
                hit      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (hit)
            ptr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
    end

endmodule

// File: rtl/fp_acc_arbiter.sv
// Round-robin share of one FP32 adder with per-requester accumulators.
// Define FP_ADD_PIPE_EN for a 2-stage pipeline with RAW hazard blocking.
module fp_acc_arbiter import fp_arb_pkg::*; #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input logic             clk,
    input logic             rst,
    fp_acc_arbiter_if.slave bus
);
    logic [NREQ-1:0]       req_live;
    logic [NREQ-1:0]       blk;
    logic [NREQ-1:0]       gnt;
    logic [IDW-1:0]        gidx;
    logic                  gv;
    fp_op_t                g_op;
    fp32_t                 g_a;
    fp32_t                 g_b;
    logic                  x_vld;
    logic [IDW-1:0]        x_id;
    fp_op_t                x_op;
    fp32_t                 x_a;
    fp32_t                 x_b;
    fp32_t                 sum;
    fp32_t                 x_res;
    logic                  res_vld;
    logic [IDW-1:0]        res_id;
    fp32_t                 res;
    logic [NREQ-1:0][31:0] acc_q;

    // Requests are ignored while reset is held.
    assign req_live = bus.req & {NREQ{~rst}};

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_live),
        .mask    (blk),
        .gnt     (gnt),
        .gnt_idx (gidx)
    );

    assign gv   = |gnt;
    assign g_op = decode_op(bus.op[gidx]);
    assign g_a  = bus.a[gidx];
    assign g_b  = (g_op == OP_ACC_ADD) ? acc_q[gidx] : bus.b[gidx];

`ifdef FP_ADD_PIPE_EN
    logic           s1_vld;
    logic [IDW-1:0] s1_id;
    fp_op_t         s1_op;
    fp32_t          s1_a;
    fp32_t          s1_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_id  <= '0;
            s1_op  <= OP_ADD;
            s1_a   <= FP_ZERO;
            s1_b   <= FP_ZERO;
        end else begin
            s1_vld <= gv;
            if (gv) begin
                s1_id <= gidx;
                s1_op <= g_op;
                s1_a  <= g_a;
                s1_b  <= g_b;
            end
        end
    end

    // An ACC_ADD must not read acc[i] before stage 1 writes it.
    always_comb begin
        blk = '0;
        for (int i = 0; i < NREQ; i++)
            blk[i] = s1_vld && (s1_op != OP_ADD) &&
                     (int'(s1_id) == i) &&
                     (decode_op(bus.op[i]) == OP_ACC_ADD);
    end

    assign x_vld = s1_vld;
    assign x_id  = s1_id;
    assign x_op  = s1_op;
    assign x_a   = s1_a;
    assign x_b   = s1_b;
`else
    assign blk   = '0;
    assign x_vld = gv;
    assign x_id  = gidx;
    assign x_op  = g_op;
    assign x_a   = g_a;
    assign x_b   = g_b;
`endif

    FP_adder u_add (
        .a   (x_a),
        .b   (x_b),
        .sum (sum)
    );

    // ACC_LD bypasses the adder so a load never sums into zero.
    assign x_res = (x_op == OP_ACC_LD) ? x_a : sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_vld <= 1'b0;
            res_id  <= '0;
            res     <= FP_ZERO;
            acc_q   <= '0;
        end else begin
            res_vld <= x_vld;
            if (x_vld) begin
                res    <= x_res;
                res_id <= x_id;
                if (x_op != OP_ADD)
                    acc_q[x_id] <= x_res;
            end
        end
    end

    assign bus.gnt     = gnt;
    assign bus.res_vld = res_vld;
    assign bus.res_id  = res_id;
    assign bus.res     = res;
    assign bus.acc     = acc_q;

endmodule

// File: tb/tb_fp_acc_arbiter.sv
// Directed bench for fp_acc_arbiter, default and FP_ADD_PIPE_EN builds.
module tb_fp_acc_arbiter;
    localparam int NREQ = 4;
`ifdef FP_ADD_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [31:0] HALF  = 32'h3F00_0000;
    localparam logic [31:0] ONE   = 32'h3F80_0000;
    localparam logic [31:0] ONEH  = 32'h3FC0_0000;
    localparam logic [31:0] TWO   = 32'h4000_0000;
    localparam logic [31:0] THREE = 32'h4040_0000;
    localparam logic [31:0] FOUR  = 32'h4080_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [31:0] t4_a [4] = '{ONE, TWO, ONE, ONEH};
    logic [31:0] t4_b [4] = '{ONE, TWO, 32'hBF00_0000, 32'h4020_0000};
    logic [31:0] t4_s [4] = '{TWO, FOUR, HALF, FOUR};
    logic [1:0]  t4_op[4] = '{2'b00, 2'b00, 2'b00, 2'b11};
    int          order[5] = '{0, 1, 2, 3, 0};
    logic [3:0]  pb_exp[6] = '{4'b1000, 4'b0001, 4'b1000,
                               4'b0001, 4'b1000, 4'b0001};
`ifdef FP_ADD_PIPE_EN
    logic [3:0]  pa_exp[4] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
    logic [31:0] acc_a = THREE;
    logic [31:0] acc_b = 32'h40C0_0000;
`else
    logic [3:0]  pa_exp[4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
    logic [31:0] acc_a = 32'h40A0_0000;
    logic [31:0] acc_b = 32'h4100_0000;
`endif

    fp_acc_arbiter_if #(.NREQ(NREQ)) bus ();

    fp_acc_arbiter #(.NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue_one(input int id, input logic [1:0] code,
                             input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] exp);
        bus.req[id] = 1'b1;
        bus.op[id]  = code;
        bus.a[id]   = x;
        bus.b[id]   = y;
        #1 chk("one_gnt", bus.gnt, 4'b0001 << id);
        tick();
        bus.req[id] = 1'b0;
        repeat (LAT - 1) tick();
        chk("one_vld", bus.res_vld, 1);
        chk("one_id", bus.res_id, id);
        chk("one_res", bus.res, exp);
        tick();
    endtask

    initial begin
        bus.req = '1;
        bus.op  = '0;
        bus.a   = '0;
        bus.b   = '0;
        repeat (2) tick();
        #1;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_vld", bus.res_vld, 0);
        chk("rst_id", bus.res_id, 0);
        chk("rst_res", bus.res, 0);
        chk("rst_acc", bus.acc, 0);
        bus.req = '0;
        rst = 1'b0;
        tick();
        chk("idle_vld", bus.res_vld, 0);
        chk("idle_acc", bus.acc, 0);

        issue_one(1, 2'b00, ONE, TWO, THREE);
        issue_one(2, 2'b01, ONE, 32'h0, ONE);
        chk("ld_acc2", bus.acc[2], ONE);
        issue_one(2, 2'b10, HALF, 32'h0, ONEH);
        chk("acc2_a", bus.acc[2], ONEH);
        issue_one(2, 2'b10, ONEH, 32'h0, THREE);
        chk("acc2_b", bus.acc[2], THREE);
        issue_one(3, 2'b00, ONE, TWO, THREE);

        for (int i = 0; i < 4; i++) begin
            bus.req[i] = 1'b1;
            bus.op[i]  = t4_op[i];
            bus.a[i]   = t4_a[i];
            bus.b[i]   = t4_b[i];
        end
        for (int c = 0; c < 5 + LAT; c++) begin
            if (c == 5) bus.req = '0;
            #1;
            if (c < 5) chk("rr_gnt", bus.gnt, 4'b0001 << order[c]);
            if (c >= LAT) begin
                chk("rr_vld", bus.res_vld, 1);
                chk("rr_id", bus.res_id, order[c - LAT]);
                chk("rr_res", bus.res, t4_s[order[c - LAT]]);
            end else
                chk("rr_vld0", bus.res_vld, 0);
            tick();
        end

        issue_one(0, 2'b01, ONE, 32'h0, ONE);
        bus.op[0] = 2'b10;
        bus.a[0]  = ONE;
        bus.req[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1 chk("solo_gnt", bus.gnt, pa_exp[c]);
            tick();
        end
        bus.req = '0;
        repeat (LAT) tick();
        chk("solo_acc0", bus.acc[0], acc_a);

        bus.op[3] = 2'b00;
        bus.a[3]  = ONE;
        bus.b[3]  = ONE;
        bus.req   = 4'b1001;
        for (int c = 0; c < 6; c++) begin
            #1 chk("fill_gnt", bus.gnt, pb_exp[c]);
            tick();
        end
        bus.req = '0;
        repeat (LAT) tick();
        chk("fill_acc0", bus.acc[0], acc_b);

        issue_one(3, 2'b00, HALF, HALF, ONE);
        bus.op[0] = 2'b00;
        bus.a[0]  = TWO;
        bus.b[0]  = TWO;
        bus.op[2] = 2'b00;
        bus.a[2]  = ONE;
        bus.b[2]  = ONE;
        bus.req   = 4'b0101;
        #1 chk("wrap_gnt", bus.gnt, 4'b0001);
        tick();
        bus.req[0] = 1'b0;
        #1 chk("wrap_gnt2", bus.gnt, 4'b0100);
        tick();
        bus.req = '0;
        repeat (LAT + 1) tick();

        bus.op[0]  = 2'b10;
        bus.a[0]   = ONE;
        bus.req[0] = 1'b1;
        #1 chk("mr_gnt", bus.gnt, 4'b0001);
`ifdef FP_ADD_PIPE_EN
        tick();
`endif
        rst = 1'b1;
        #1 chk("mr_gnt_rst", bus.gnt, 0);
        tick();
        chk("mr_vld", bus.res_vld, 0);
        chk("mr_acc0", bus.acc[0], 0);
        bus.req = '0;
        rst = 1'b0;
        tick();
        chk("mr_vld2", bus.res_vld, 0);
        tick();
        chk("mr_vld3", bus.res_vld, 0);
        chk("mr_acc", bus.acc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
